// File: rtl/moving_avg_filter_pkg.sv
// Shared constants and helpers for the moving-average filter slice.
package filter_pkg;

    localparam int DATA_W_DEF         = 16;
    localparam int MAX_LOG2_DEPTH_DEF = 4;

    function automatic int clamp_mode(input int mode, input int max_log2);
        return (mode > max_log2) ? max_log2 : mode;
    endfunction

    // Sign-extends the low data_w bits of value; the caller truncates to ACC_W.
    function automatic logic signed [63:0] sext_acc(input logic [63:0] value, input int data_w);
        logic signed [63:0] tmp;
        tmp = $signed(value << (64 - data_w));
        return tmp >>> (64 - data_w);
    endfunction

endpackage

// File: rtl/moving_avg_filter_if.sv
// Sample/result bundle between the SPI reader side and the filter.
interface moving_avg_filter_if
    import filter_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CHANNELS       = 2,
    parameter int MAX_LOG2_DEPTH = MAX_LOG2_DEPTH_DEF
);
    localparam int MODE_W = $clog2(MAX_LOG2_DEPTH + 1);

    logic [MODE_W-1:0]          mode;
    logic [CHANNELS-1:0]        invert_mask;
    logic                       sample_valid;
    logic [CHANNELS*DATA_W-1:0] sample_in;
    logic                       out_valid;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       settled;

    modport master (
        output mode, invert_mask, sample_valid, sample_in,
        input  out_valid, out_data, settled
    );

    modport slave (
        input  mode, invert_mask, sample_valid, sample_in,
        output out_valid, out_data, settled
    );

endinterface

// File: rtl/moving_avg_filter_channel.sv
// One channel: ring buffer, running sum and registered output for a single axis.
module mavg_channel
    import filter_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_LOG2_DEPTH = MAX_LOG2_DEPTH_DEF,
    parameter int MODE_W         = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_valid,
    input  logic                      flush,
    input  logic                      invert,
    input  logic [DATA_W-1:0]         sample,
    input  logic [MAX_LOG2_DEPTH-1:0] wr_ptr,
    input  logic [MAX_LOG2_DEPTH-1:0] rd_ptr,
    input  logic                      full_now,
    input  logic                      full_next,
    input  logic [MODE_W-1:0]         m,
    output logic [DATA_W-1:0]         out_data
);
    localparam int ACC_W = DATA_W + MAX_LOG2_DEPTH;
    localparam int DEPTH = 1 << MAX_LOG2_DEPTH;

    logic [DATA_W-1:0]       x;
    logic [DATA_W-1:0]       oldest;
    logic [DATA_W-1:0]       ring_q [DEPTH];
    logic [DATA_W-1:0]       ring_d [DEPTH];
    logic signed [ACC_W-1:0] sum_q, sum_d, sum_base, x_ext, old_ext;
    logic [DATA_W-1:0]       out_q, out_d;

    // A flush zeroes the sum before the new sample is folded in.
    always_comb begin
        x        = invert ? ~sample : sample;
        oldest   = ring_q[rd_ptr];
        x_ext    = ACC_W'(sext_acc(64'(x), DATA_W));
        old_ext  = full_now ? ACC_W'(sext_acc(64'(oldest), DATA_W)) : '0;
        sum_base = flush ? '0 : sum_q;
        sum_d    = sum_base;
        ring_d   = ring_q;
        out_d    = out_q;
        if (sample_valid) begin
            sum_d          = sum_base + x_ext - old_ext;
            ring_d[wr_ptr] = x;
            out_d          = full_next ? DATA_W'(sum_d >>> m) : x;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
            out_q <= '0;
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
        end else begin
            sum_q  <= sum_d;
            out_q  <= out_d;
            ring_q <= ring_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel running-sum moving average with a runtime-selectable 2^mode window.
module moving_avg_filter
    import filter_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CHANNELS       = 2,
    parameter int MAX_LOG2_DEPTH = MAX_LOG2_DEPTH_DEF
) (
    input logic               clk,
    input logic               reset_n,
    moving_avg_filter_if.slave bus
);
    localparam int MODE_W = $clog2(MAX_LOG2_DEPTH + 1);
    localparam int PTR_W  = MAX_LOG2_DEPTH;
    localparam int FILL_W = MAX_LOG2_DEPTH + 1;

    logic [MODE_W-1:0] m, mode_q, mode_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr;
    logic [FILL_W-1:0] fill_q, fill_d, fill_eff, win_n;
    logic              flush, full_now, full_next;
    logic              out_valid_q, out_valid_d;
    logic              settled_q, settled_d;
    logic [DATA_W-1:0] ch_out [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] out_flat;

    // Window bookkeeping shared by every channel; a mode change restarts the fill.
    always_comb begin
        m           = MODE_W'(clamp_mode(int'(bus.mode), MAX_LOG2_DEPTH));
        win_n       = FILL_W'(1) << m;
        flush       = (m != mode_q);
        fill_eff    = flush ? '0 : fill_q;
        full_now    = (fill_eff == win_n);
        rd_ptr      = wr_ptr_q - win_n[PTR_W-1:0];
        mode_d      = m;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_eff;
        out_valid_d = 1'b0;
        settled_d   = flush ? 1'b0 : settled_q;
        if (bus.sample_valid) begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            if (!full_now) fill_d = fill_eff + FILL_W'(1);
            out_valid_d = 1'b1;
            settled_d   = (fill_d == win_n);
        end
        full_next = (fill_d == win_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            settled_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            settled_q   <= settled_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        mavg_channel #(
            .DATA_W         (DATA_W),
            .MAX_LOG2_DEPTH (MAX_LOG2_DEPTH),
            .MODE_W         (MODE_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .sample_valid (bus.sample_valid),
            .flush        (flush),
            .invert       (bus.invert_mask[c]),
            .sample       (bus.sample_in[c*DATA_W +: DATA_W]),
            .wr_ptr       (wr_ptr_q),
            .rd_ptr       (rd_ptr),
            .full_now     (full_now),
            .full_next    (full_next),
            .m            (m),
            .out_data     (ch_out[c])
        );
    end

    always_comb begin
        out_flat = '0;
        for (int c = 0; c < CHANNELS; c++) out_flat[c*DATA_W +: DATA_W] = ch_out[c];
    end

    assign bus.out_data  = out_flat;
    assign bus.out_valid = out_valid_q;
    assign bus.settled   = settled_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed scenario bench for moving_avg_filter with two 16-bit channels.
module tb_moving_avg_filter;

    logic clk;
    logic reset_n;
    int   n_compared;
    int   n_mismatched;

    moving_avg_filter_if #(.DATA_W(16), .CHANNELS(2), .MAX_LOG2_DEPTH(4)) bus ();

    moving_avg_filter #(.DATA_W(16), .CHANNELS(2), .MAX_LOG2_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one cycle of input and returns 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b);
        bus.sample_valid = v;
        bus.sample_in    = {b, a};
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_compared += 3;
        if (bus.out_data !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_data got %h want 00000000", bus.out_data);
        end
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        if (bus.settled !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_settled got %b want 0", bus.settled);
        end
    endtask

    task automatic test_mode0();
        bus.mode = 3'd0;
        step(1'b1, 16'h0010, 16'hFFF0);
        n_compared += 4;
        if (bus.out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mode0_valid got %b want 1", bus.out_valid);
        end
        if (bus.out_data[15:0] !== 16'h0010) begin
            n_mismatched++;
            $display("[TB] FAIL mode0_ch0 got %h want 0010", bus.out_data[15:0]);
        end
        if (bus.out_data[31:16] !== 16'hFFF0) begin
            n_mismatched++;
            $display("[TB] FAIL mode0_ch1 got %h want fff0", bus.out_data[31:16]);
        end
        if (bus.settled !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mode0_settled got %b want 1", bus.settled);
        end
    endtask

    task automatic test_window4();
        logic [15:0] samp [5];
        logic [15:0] expv [5];
        logic        sett [5];
        samp = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20};
        expv = '{16'd4, 16'd8, 16'd12, 16'd10, 16'd14};
        sett = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.mode = 3'd2;
        step(1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, samp[i], 16'h0);
            n_compared += 2;
            if (bus.out_data[15:0] !== expv[i]) begin
                n_mismatched++;
                $display("[TB] FAIL win4_out[%0d] got %0d want %0d", i, bus.out_data[15:0], expv[i]);
            end
            if (bus.settled !== sett[i]) begin
                n_mismatched++;
                $display("[TB] FAIL win4_settled[%0d] got %b want %b", i, bus.settled, sett[i]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 16'h1234, 16'h1234);
        n_compared += 3;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_valid got %b want 0", bus.out_valid);
        end
        if (bus.out_data[15:0] !== 16'd14) begin
            n_mismatched++;
            $display("[TB] FAIL hold_out got %0d want 14", bus.out_data[15:0]);
        end
        if (bus.settled !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL hold_settled got %b want 1", bus.settled);
        end
    endtask

    task automatic test_negative_floor();
        bus.mode = 3'd1;
        step(1'b0, 16'h0, 16'h0);
        step(1'b1, 16'hFFFD, 16'h0);
        n_compared += 2;
        if (bus.out_data[15:0] !== 16'hFFFD) begin
            n_mismatched++;
            $display("[TB] FAIL neg_first got %h want fffd", bus.out_data[15:0]);
        end
        if (bus.settled !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL neg_first_settled got %b want 0", bus.settled);
        end
        step(1'b1, 16'hFFFC, 16'h0);
        n_compared += 2;
        if (bus.out_data[15:0] !== 16'hFFFC) begin
            n_mismatched++;
            $display("[TB] FAIL neg_floor got %h want fffc", bus.out_data[15:0]);
        end
        if (bus.settled !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL neg_settled got %b want 1", bus.settled);
        end
    endtask

    task automatic test_invert();
        bus.mode        = 3'd0;
        bus.invert_mask = 2'b01;
        step(1'b0, 16'h0, 16'h0);
        step(1'b1, 16'h0005, 16'h0005);
        n_compared += 2;
        if (bus.out_data[15:0] !== 16'hFFFA) begin
            n_mismatched++;
            $display("[TB] FAIL invert_ch0 got %h want fffa", bus.out_data[15:0]);
        end
        if (bus.out_data[31:16] !== 16'h0005) begin
            n_mismatched++;
            $display("[TB] FAIL invert_ch1 got %h want 0005", bus.out_data[31:16]);
        end
        bus.invert_mask = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [15:0] expv;
        logic        sett;
        bus.mode = 3'd4;
        step(1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 16'(k), 16'h0);
            expv = (k < 15) ? 16'(k) : 16'(k - 8);
            sett = (k >= 15);
            n_compared += 3;
            if (bus.out_valid !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL ramp_valid[%0d] got %b want 1", k, bus.out_valid);
            end
            if (bus.out_data[15:0] !== expv) begin
                n_mismatched++;
                $display("[TB] FAIL ramp_out[%0d] got %0d want %0d", k, bus.out_data[15:0], expv);
            end
            if (bus.settled !== sett) begin
                n_mismatched++;
                $display("[TB] FAIL ramp_settled[%0d] got %b want %b", k, bus.settled, sett);
            end
        end
    endtask

    task automatic test_mode_switch();
        bus.mode = 3'd2;
        step(1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd7, 16'd7);
        n_compared += 2;
        if (bus.out_data[15:0] !== 16'd7) begin
            n_mismatched++;
            $display("[TB] FAIL pre_switch_out got %0d want 7", bus.out_data[15:0]);
        end
        if (bus.settled !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL pre_switch_settled got %b want 1", bus.settled);
        end
        bus.mode = 3'd4;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'd100, 16'd100);
            n_compared += 2;
            if (bus.out_data[15:0] !== 16'd100) begin
                n_mismatched++;
                $display("[TB] FAIL switch_out[%0d] got %0d want 100", i, bus.out_data[15:0]);
            end
            if (bus.settled !== (i == 15)) begin
                n_mismatched++;
                $display("[TB] FAIL switch_settled[%0d] got %b want %b", i, bus.settled, (i == 15));
            end
        end
    endtask

    task automatic test_reset_midstream();
        bus.mode = 3'd2;
        #2;
        reset_n = 1'b0;
        #1;
        n_compared += 3;
        if (bus.out_data !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_out got %h want 00000000", bus.out_data);
        end
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_valid got %b want 0", bus.out_valid);
        end
        if (bus.settled !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_settled got %b want 0", bus.settled);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'd8, 16'd8);
            n_compared += 2;
            if (bus.out_data[15:0] !== 16'd8) begin
                n_mismatched++;
                $display("[TB] FAIL postrst_out[%0d] got %0d want 8", i, bus.out_data[15:0]);
            end
            if (bus.settled !== (i == 3)) begin
                n_mismatched++;
                $display("[TB] FAIL postrst_settled[%0d] got %b want %b", i, bus.settled, (i == 3));
            end
        end
    endtask

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        reset_n          = 1'b0;
        bus.mode         = 3'd0;
        bus.invert_mask  = 2'b00;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        #2;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_mode0();
        test_window4();
        test_hold();
        test_negative_floor();
        test_invert();
        test_back_to_back();
        test_mode_switch();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
